// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: decodes a multiplexed, active-low 7-segment bus back
// into a hex word. Each digit is filtered for stability. One word is
// assembled per scan frame. Illegal glyphs and illegal digit selects are
// flagged.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   seg_n       segment pattern, active-low, bit0=a .. bit6=g
//   dig_sel     one-hot digit select, bit i = digit i (digit 0 = LS nibble)
//   seg_strobe  qualifies seg_n/dig_sel
//   value       last emitted word, nibble i = digit i
//   blank_mask  digits committed as blank in the emitted word
//   out_valid   one-cycle pulse when value/blank_mask update
//   changed     with out_valid: emitted word differs from the previous one
//   err_glyph   one-cycle pulse: strobed pattern not a known glyph
//   err_sel     one-cycle pulse: strobed dig_sel not one-hot
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned STABLE_COUNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    seg_strobe,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    out_valid,
  output logic                    changed,
  output logic                    err_glyph,
  output logic                    err_sel
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0]      STABLE   = CNT_W'(STABLE_COUNT);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  typedef enum logic [1:0] {SYNC, COLLECT, EMIT} state_t;

  state_t                state_q, state_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                  emit_c;

  // Per-digit stability state; last_q holds {blank, nibble}
  logic [4:0]       last_q    [NUM_DIGITS];
  logic [CNT_W-1:0] cnt_q     [NUM_DIGITS];
  logic [3:0]       com_nib_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] com_blank_q, committed_q;
  logic                  emitted_q;

  logic             dec_legal, dec_blank;
  logic [3:0]       dec_nib;
  logic [4:0]       glyph, cur_last;
  logic [CNT_W-1:0] cur_cnt, new_cnt;
  logic             sel_onehot, samp_ok, samp_legal, do_commit;
  logic [VAL_W-1:0] word;

  // Glyph table lookup
  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (seg_n)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  assign sel_onehot = $onehot(dig_sel);
  assign samp_ok    = seg_strobe && sel_onehot;
  assign samp_legal = samp_ok && dec_legal;
  assign glyph      = {dec_blank, dec_nib};

  // Next stability count for the selected digit (one-hot, so a plain mux)
  always_comb begin
    cur_last = '0;
    cur_cnt  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) begin
        cur_last = last_q[i];
        cur_cnt  = cnt_q[i];
      end
    end
    if (!dec_legal)
      new_cnt = '0;
    else if (glyph == cur_last)
      new_cnt = (cur_cnt < STABLE) ? cur_cnt + CNT_W'(1) : cur_cnt;
    else
      new_cnt = CNT_W'(1);
    do_commit = dec_legal && (new_cnt == STABLE);
  end

  // Per-digit stability and commit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        last_q[i]    <= '0;
        cnt_q[i]     <= '0;
        com_nib_q[i] <= '0;
      end
      com_blank_q <= '0;
      committed_q <= '0;
    end else if (samp_ok) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_sel[i]) begin
          cnt_q[i] <= new_cnt;
          if (dec_legal) last_q[i] <= glyph;
          if (do_commit) begin
            com_nib_q[i]   <= dec_nib;
            com_blank_q[i] <= dec_blank;
            committed_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      seen_q  <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
    end
  end

  // Frame FSM next state; a frame opens only on a legal digit-0 strobe
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    emit_c  = 1'b0;
    case (state_q)
      SYNC: begin
        if (samp_legal && dig_sel[0]) begin
          seen_d  = NUM_DIGITS'(1);
          state_d = (NUM_DIGITS == 1) ? EMIT : COLLECT;
        end
      end
      COLLECT: begin
        if (samp_ok) begin
          seen_d = seen_q | dig_sel;
          if ((seen_q | dig_sel) == ALL_SEEN) state_d = EMIT;
        end
      end
      EMIT: begin
        emit_c  = 1'b1;
        seen_d  = '0;
        state_d = SYNC;
      end
      default: begin
        seen_d  = '0;
        state_d = SYNC;
      end
    endcase
  end

  // Committed nibbles packed into the output word
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_DIGITS; i++) word[4*i +: 4] = com_nib_q[i];
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      value      <= '0;
      blank_mask <= '0;
      out_valid  <= 1'b0;
      changed    <= 1'b0;
      err_glyph  <= 1'b0;
      err_sel    <= 1'b0;
      emitted_q  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      changed   <= 1'b0;
      err_glyph <= samp_ok && !dec_legal;
      err_sel   <= seg_strobe && !sel_onehot;
      if (emit_c && (&committed_q)) begin
        value      <= word;
        blank_mask <= com_blank_q;
        out_valid  <= 1'b1;
        changed    <= !emitted_q || ({word, com_blank_q} != {value, blank_mask});
        emitted_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a 2-digit/3-sample instance and a
// 1-digit/1-sample instance sharing clock and reset.
module tb_seg7_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_n;
  logic [1:0] dig_sel;
  logic       seg_strobe;
  logic [7:0] value;
  logic [1:0] blank_mask;
  logic       out_valid, changed, err_glyph, err_sel;

  logic [6:0] seg_n1;
  logic [0:0] dig_sel1;
  logic       seg_strobe1;
  logic [3:0] value1;
  logic [0:0] blank_mask1;
  logic       out_valid1, changed1, err_glyph1, err_sel1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(2), .STABLE_COUNT(3)) u_dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .dig_sel(dig_sel),
    .seg_strobe(seg_strobe), .value(value), .blank_mask(blank_mask),
    .out_valid(out_valid), .changed(changed), .err_glyph(err_glyph),
    .err_sel(err_sel)
  );

  seg7_scan_decoder #(.NUM_DIGITS(1), .STABLE_COUNT(1)) u_dut1 (
    .clk(clk), .rst(rst), .seg_n(seg_n1), .dig_sel(dig_sel1),
    .seg_strobe(seg_strobe1), .value(value1), .blank_mask(blank_mask1),
    .out_valid(out_valid1), .changed(changed1), .err_glyph(err_glyph1),
    .err_sel(err_sel1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobed cycle on the 2-digit instance; returns 1ns after the edge
  task automatic pulse(input logic [6:0] s, input logic [1:0] sel);
    seg_n      = s;
    dig_sel    = sel;
    seg_strobe = 1'b1;
    @(posedge clk); #1;
    seg_strobe = 1'b0;
  endtask

  task automatic idle;
    @(posedge clk); #1;
  endtask

  // d0 strobe, d1 strobe, then the EMIT cycle; out_valid is visible on return
  task automatic frame(input logic [6:0] s0, input logic [6:0] s1);
    pulse(s0, 2'b01);
    pulse(s1, 2'b10);
    idle();
  endtask

  task automatic chk_emit(input string tag, input logic [7:0] v,
                          input logic [1:0] b, input logic c);
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    chk({tag, "_val"}, 32'(value), 32'(v));
    chk({tag, "_blank"}, 32'(blank_mask), 32'(b));
    chk({tag, "_chg"}, 32'(changed), 32'(c));
  endtask

  initial begin
    rst = 1'b1; seg_n = 7'h7F; dig_sel = 2'b00; seg_strobe = 1'b0;
    seg_n1 = 7'h7F; dig_sel1 = 1'b0; seg_strobe1 = 1'b0;
    idle(); idle();
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_blank", 32'(blank_mask), 32'h0);
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_chg", 32'(changed), 32'h0);
    chk("rst_errg", 32'(err_glyph), 32'h0);
    chk("rst_errs", 32'(err_sel), 32'h0);
    chk("rst_ov1", 32'(out_valid1), 32'h0);
    rst = 1'b0;

    // First committed word needs three frames
    frame(7'h24, 7'h12); chk("f1_ov", 32'(out_valid), 32'h0);
    frame(7'h24, 7'h12); chk("f2_ov", 32'(out_valid), 32'h0);
    frame(7'h24, 7'h12); chk_emit("f3", 8'h52, 2'b00, 1'b1);
    frame(7'h24, 7'h12); chk_emit("f4", 8'h52, 2'b00, 1'b0);
    frame(7'h24, 7'h12); chk_emit("f5", 8'h52, 2'b00, 1'b0);

    // d1 -> E: old word until the third frame
    frame(7'h24, 7'h06); chk_emit("e1", 8'h52, 2'b00, 1'b0);
    frame(7'h24, 7'h06); chk_emit("e2", 8'h52, 2'b00, 1'b0);
    frame(7'h24, 7'h06); chk_emit("e3", 8'hE2, 2'b00, 1'b1);

    // Blank digit 0
    frame(7'h7F, 7'h79);
    frame(7'h7F, 7'h79);
    frame(7'h7F, 7'h79); chk_emit("blk", 8'h10, 2'b01, 1'b1);

    // Back to 0x52, two d1 samples of E, then an illegal glyph
    frame(7'h24, 7'h12);
    frame(7'h24, 7'h12);
    frame(7'h24, 7'h12); chk_emit("s3", 8'h52, 2'b00, 1'b1);
    frame(7'h24, 7'h06);
    frame(7'h24, 7'h06); chk_emit("pre", 8'h52, 2'b00, 1'b0);
    pulse(7'h24, 2'b01);
    pulse(7'h55, 2'b10);
    chk("eg_pulse", 32'(err_glyph), 32'h1);
    chk("eg_sel", 32'(err_sel), 32'h0);
    idle();
    chk("eg_clear", 32'(err_glyph), 32'h0);
    chk_emit("eg_hold", 8'h52, 2'b00, 1'b0);
    frame(7'h24, 7'h06); chk_emit("r1", 8'h52, 2'b00, 1'b0);
    frame(7'h24, 7'h06); chk_emit("r2", 8'h52, 2'b00, 1'b0);
    frame(7'h24, 7'h06); chk_emit("r3", 8'hE2, 2'b00, 1'b1);

    // Non-one-hot selects are ignored
    pulse(7'h24, 2'b11);
    chk("es_11", 32'(err_sel), 32'h1);
    pulse(7'h24, 2'b00);
    chk("es_00", 32'(err_sel), 32'h1);
    pulse(7'h24, 2'b01);
    chk("es_clear", 32'(err_sel), 32'h0);
    pulse(7'h12, 2'b11);
    chk("es_11b", 32'(err_sel), 32'h1);
    idle();
    chk("es_noframe", 32'(out_valid), 32'h0);
    pulse(7'h06, 2'b10);
    idle();
    chk_emit("es_frame", 8'hE2, 2'b00, 1'b0);

    // Reset mid-COLLECT
    pulse(7'h24, 2'b01);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("mr_value", 32'(value), 32'h0);
    chk("mr_blank", 32'(blank_mask), 32'h0);
    chk("mr_ov", 32'(out_valid), 32'h0);
    chk("mr_chg", 32'(changed), 32'h0);
    frame(7'h24, 7'h12); chk("mr1_ov", 32'(out_valid), 32'h0);
    frame(7'h24, 7'h12); chk("mr2_ov", 32'(out_valid), 32'h0);
    frame(7'h24, 7'h12); chk_emit("mr3", 8'h52, 2'b00, 1'b1);

    // Single digit, commit on first sample
    seg_n1 = 7'h0E; dig_sel1 = 1'b1; seg_strobe1 = 1'b1;
    @(posedge clk); #1;
    seg_strobe1 = 1'b0;
    chk("d1_lat1", 32'(out_valid1), 32'h0);
    @(posedge clk); #1;
    chk("d1_ov", 32'(out_valid1), 32'h1);
    chk("d1_val", 32'(value1), 32'hF);
    chk("d1_chg", 32'(changed1), 32'h1);
    @(posedge clk); #1;
    chk("d1_pulse", 32'(out_valid1), 32'h0);
    // Three back-to-back strobes; the middle one lands in EMIT
    seg_strobe1 = 1'b1;
    @(posedge clk); #1;
    chk("bb_e0", 32'(out_valid1), 32'h0);
    @(posedge clk); #1;
    chk("bb_ov1", 32'(out_valid1), 32'h1);
    chk("bb_val1", 32'(value1), 32'hF);
    chk("bb_chg1", 32'(changed1), 32'h0);
    @(posedge clk); #1;
    seg_strobe1 = 1'b0;
    chk("bb_gap", 32'(out_valid1), 32'h0);
    @(posedge clk); #1;
    chk("bb_ov2", 32'(out_valid1), 32'h1);
    chk("bb_val2", 32'(value1), 32'hF);
    chk("bb_err", 32'({err_glyph1, err_sel1}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the 7-segment display interface: samples a multiplexed, active-low segment bus and decodes each glyph back to its 4-bit hex value.
- Filters each digit for stability, assembles one word per scan frame, and flags illegal glyphs or digit selects.
- Sits between a display-scan tap (or an external 7-seg source) and the ALU/test logic that checks what was shown.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits; legal range 1..8.
- STABLE_COUNT, 3, consecutive identical samples needed before a digit's value is committed; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_n  input  7  segment pattern, active-low; bit0=a, bit1=b, ..., bit6=g.
- dig_sel  input  NUM_DIGITS  one-hot digit select; bit i = digit i, digit 0 is the least significant nibble.
- seg_strobe  input  1  seg_n/dig_sel are sampled only in cycles with seg_strobe=1.
- value  output  4*NUM_DIGITS  last emitted word; nibble i = digit i.
- blank_mask  output  NUM_DIGITS  bit i=1 if digit i was committed as blank (its nibble reads 0).
- out_valid  output  1  one-cycle pulse when value/blank_mask update.
- changed  output  1  qualifies out_valid; 1 if the word differs from the previous emission.
- err_glyph  output  1  one-cycle pulse: strobed pattern not in the glyph table.
- err_sel  output  1  one-cycle pulse: strobed dig_sel not one-hot.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - value=0, blank_mask=0, out_valid=0, changed=0, err_glyph=0, err_sel=0.
  - All per-digit state cleared; FSM to SYNC.
  - Reset mid-frame discards the partial frame.
- Glyph table, seg_n as {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - 7F = blank.
  - Any other pattern is illegal.
- Strobe handling, per strobed cycle:
  - dig_sel not one-hot: sample ignored, err_sel=1 next cycle, no state change.
  - Illegal glyph on digit i: err_glyph=1 next cycle; digit i stability counter cleared; committed value retained; frame-seen bit is still set.
  - Legal glyph equal to digit i's last sample: counter saturating +1.
  - Legal glyph that differs: last sample replaced, counter=1.
  - Counter reaching STABLE_COUNT: digit i's nibble and blank bit committed and committed_i set. With STABLE_COUNT=1 the first sample commits.
- Frame FSM:
  - SYNC: wait for a legal strobe on digit 0, then go to COLLECT with the seen mask = {digit 0}. Strobes on other digits only update stability state.
  - COLLECT: OR the strobed digit into the seen mask. When the mask is all ones, go to EMIT. A repeated digit within a frame is allowed and just updates stability.
  - EMIT (one cycle): if every committed_i=1, drive value/blank_mask, pulse out_valid, and set changed = (new word != previous word). changed=1 on the first emission after reset. If any digit is uncommitted, emit nothing. Clear the seen mask and go to SYNC.
  - A strobe arriving during EMIT is processed normally for stability; the frame does not count it.
- Latency: out_valid rises 2 cycles after the strobe that completes the frame (1 cycle into EMIT, registered output). err_* rise 1 cycle after the offending strobe.
- NUM_DIGITS=1: every legal strobe on digit 0 completes a frame.
- No flow control; downstream must accept out_valid whenever it pulses.

Test Plan:
- NUM_DIGITS=2, STABLE_COUNT=3. Alternate strobes (d0=24, d1=12) for 3 frames → a single out_valid at the end of frame 3 with value=0x52, changed=1, blank_mask=0. Frames 1–2 emit nothing.
- Continue from that state with 2 more identical frames → out_valid each frame with value=0x52, changed=0. Then switch d1 to 06 → after 3 frames value=0xE2, changed=1.
- Strobe d0=7F, d1=79 for 3 frames → value=0x10, blank_mask=2'b01.
- Stable 0x52, then one d1 strobe of 0x55 → err_glyph pulse 1 cycle later. The next emission still holds value=0x52. d1's counter restarts, so any changed d1 glyph needs 3 further samples to commit.
- dig_sel=2'b11 or 2'b00 with a strobe → err_sel pulse, no counter or seen-mask change. Then assert rst mid-COLLECT → all outputs 0. The next out_valid needs 3 full fresh frames.
- STABLE_COUNT=1, NUM_DIGITS=1, seg_n=0E on every strobe → out_valid 2 cycles after each strobe, value=0xF. Back-to-back strobes are handled, including a strobe during EMIT.
